// File: rtl/fifo_pkg.sv
// ============================================================================
// Module  : fifo_pkg
// Brief   : Shared constants, state encoding and decode helper for fifo_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

  localparam int ADDR_W = 3;
  localparam int DEPTH  = 2 ** ADDR_W;

  // State records the operation performed on the most recent edge.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WRITE  = 3'd1;
  localparam logic [2:0] ST_READ   = 3'd2;
  localparam logic [2:0] ST_RDWR   = 3'd3;
  localparam logic [2:0] ST_WR_ERR = 3'd4;
  localparam logic [2:0] ST_RD_ERR = 3'd5;

  function automatic logic [2:0] next_state(
    input logic wr_ok,
    input logic rd_ok,
    input logic wr_req,
    input logic rd_req
  );
    logic [2:0] st;
    st = ST_IDLE;
    if (wr_ok && rd_ok) begin
      st = ST_RDWR;
    end else if (wr_ok) begin
      st = ST_WRITE;
    end else if (rd_ok) begin
      st = ST_READ;
    end else if (wr_req) begin
      st = ST_WR_ERR;
    end else if (rd_req) begin
      st = ST_RD_ERR;
    end
    return st;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_ctrl_if.sv
// ============================================================================
// Module  : fifo_ctrl_if
// Brief   : FIFO request/status and register-file port bundle for fifo_ctrl.
//           Optional almost_* signals exist when FIFO_CTRL_ALMOST_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) ();

  logic              wr_en;
  logic              rd_en;
  logic              we;
  logic [ADDR_W-1:0] wAddr;
  logic [ADDR_W-1:0] rAddr;
  logic [DATA_W-1:0] rData;
  logic [DATA_W-1:0] dout;
  logic [ADDR_W:0]   data_count;
  logic              full;
  logic              empty;
  logic              wr_ack;
  logic              wr_err;
  logic              rd_ack;
  logic              rd_err;
`ifdef FIFO_CTRL_ALMOST_EN
  logic              almost_full;
  logic              almost_empty;
`endif

  // master: the FIFO user plus register file; slave: the controller.
  modport master (
    output wr_en, rd_en, rData,
    input  we, wAddr, rAddr, dout, data_count, full, empty,
`ifdef FIFO_CTRL_ALMOST_EN
    input  almost_full, almost_empty,
`endif
    input  wr_ack, wr_err, rd_ack, rd_err
  );

  modport slave (
    input  wr_en, rd_en, rData,
    output we, wAddr, rAddr, dout, data_count, full, empty,
`ifdef FIFO_CTRL_ALMOST_EN
    output almost_full, almost_empty,
`endif
    output wr_ack, wr_err, rd_ack, rd_err
  );

endinterface

`default_nettype wire

// File: rtl/fifo_ptr.sv
// ============================================================================
// Module  : fifo_ptr
// Brief   : Wrapping ADDR_W-bit pointer with increment enable, async reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ptr #(
  parameter int ADDR_W = 3
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              inc_i,
  output logic      [ADDR_W-1:0] ptr_o
);

  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;

  // Natural overflow gives the modulo-DEPTH wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

`default_nettype wire

// File: rtl/fifo_ctrl.sv
// ============================================================================
// Module  : fifo_ctrl
// Brief   : Sequencing controller turning an external register file into a
//           synchronous FIFO. Define FIFO_CTRL_ALMOST_EN for almost_* flags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = fifo_pkg::ADDR_W
) (
  input  wire logic   clk,
  input  wire logic   reset,
  fifo_ctrl_if.slave  bus
);

  import fifo_pkg::*;

  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] dout_d;
  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic              cross_err_q;
  logic              cross_err_d;

  logic              full_w;
  logic              empty_w;
  logic              wr_ok_w;
  logic              rd_ok_w;
  logic [ADDR_W-1:0] head_w;
  logic [ADDR_W-1:0] tail_w;

  assign full_w  = (count_q == CNT_FULL);
  assign empty_w = (count_q == '0);

  // A read on an empty FIFO is never satisfied by the word written alongside it.
  assign wr_ok_w = bus.wr_en && !full_w;
  assign rd_ok_w = bus.rd_en && !empty_w;

  fifo_ptr #(
    .ADDR_W (ADDR_W)
  ) u_head (
    .clk   (clk),
    .reset (reset),
    .inc_i (rd_ok_w),
    .ptr_o (head_w)
  );

  fifo_ptr #(
    .ADDR_W (ADDR_W)
  ) u_tail (
    .clk   (clk),
    .reset (reset),
    .inc_i (wr_ok_w),
    .ptr_o (tail_w)
  );

  always_comb begin
    count_d     = count_q;
    dout_d      = dout_q;
    state_d     = next_state(wr_ok_w, rd_ok_w, bus.wr_en, bus.rd_en);
    cross_err_d = bus.wr_en && bus.rd_en && (full_w || empty_w);
    case ({wr_ok_w, rd_ok_w})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (rd_ok_w) begin
      dout_d = bus.rData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      dout_q      <= '0;
      state_q     <= ST_IDLE;
      cross_err_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      dout_q      <= dout_d;
      state_q     <= state_d;
      cross_err_q <= cross_err_d;
    end
  end

`ifdef FIFO_CTRL_ALMOST_EN
  logic almost_full_q;
  logic almost_empty_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= (count_d >= (CNT_FULL - CNT_ONE));
      almost_empty_q <= (count_d <= CNT_ONE);
    end
  end

  assign bus.almost_full  = almost_full_q;
  assign bus.almost_empty = almost_empty_q;
`endif

  // A both-request that was half rejected lands in WRITE or READ; the
  // cross_err bit supplies the error pulse for the rejected half.
  assign bus.wr_ack = (state_q == ST_WRITE) || (state_q == ST_RDWR);
  assign bus.rd_ack = (state_q == ST_READ)  || (state_q == ST_RDWR);
  assign bus.wr_err = (state_q == ST_WR_ERR) || ((state_q == ST_READ)  && cross_err_q);
  assign bus.rd_err = (state_q == ST_RD_ERR) || ((state_q == ST_WRITE) && cross_err_q);

  assign bus.we         = wr_ok_w;
  assign bus.wAddr      = tail_w;
  assign bus.rAddr      = head_w;
  assign bus.dout       = dout_q;
  assign bus.data_count = count_q;
  assign bus.full       = full_w;
  assign bus.empty      = empty_w;

endmodule

`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
// ============================================================================
// Module  : tb_fifo_ctrl
// Brief   : Self-checking bench for fifo_ctrl against a queue-based FIFO model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_ctrl;

  localparam int DW  = 32;
  localparam int AW  = 3;
  localparam int DEP = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  fifo_ctrl #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Register file sitting beside the controller.
  logic [DW-1:0] mem [DEP];
  logic [DW-1:0] wdata;
  assign bus.rData = mem[bus.rAddr];
  always @(posedge clk) if (bus.we) mem[bus.wAddr] <= wdata;

  // Reference model.
  logic [DW-1:0] q[$];
  int            head_m, tail_m;
  logic [DW-1:0] dout_m;
  bit            wa_m, we_m, ra_m, re_m;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    head_m = 0;
    tail_m = 0;
    dout_m = '0;
    wa_m = 0; we_m = 0; ra_m = 0; re_m = 0;
  endtask

  task automatic check_outputs();
    chk("data_count", 64'(bus.data_count), 64'(q.size()));
    chk("full",   64'(bus.full),   64'(q.size() == DEP));
    chk("empty",  64'(bus.empty),  64'(q.size() == 0));
    chk("dout",   64'(bus.dout),   64'(dout_m));
    chk("wr_ack", 64'(bus.wr_ack), 64'(wa_m));
    chk("wr_err", 64'(bus.wr_err), 64'(we_m));
    chk("rd_ack", 64'(bus.rd_ack), 64'(ra_m));
    chk("rd_err", 64'(bus.rd_err), 64'(re_m));
`ifdef FIFO_CTRL_ALMOST_EN
    chk("almost_full",  64'(bus.almost_full),  64'(q.size() >= DEP - 1));
    chk("almost_empty", 64'(bus.almost_empty), 64'(q.size() <= 1));
`endif
  endtask

  // One request cycle: drive on the falling edge, check the combinational
  // write-side outputs, then check registered results just after the rise.
  task automatic step(input bit w, input bit r, input logic [DW-1:0] d);
    bit aw, ar;
    @(negedge clk);
    bus.wr_en = w;
    bus.rd_en = r;
    wdata     = d;
    aw = w && (q.size() < DEP);
    ar = r && (q.size() > 0);
    #1;
    chk("we",    64'(bus.we),    64'(aw));
    chk("wAddr", 64'(bus.wAddr), 64'(tail_m));
    chk("rAddr", 64'(bus.rAddr), 64'(head_m));
    if (ar) begin
      dout_m = q.pop_front();
      head_m = (head_m + 1) % DEP;
    end
    if (aw) begin
      q.push_back(d);
      tail_m = (tail_m + 1) % DEP;
    end
    wa_m = aw;
    we_m = w && !aw;
    ra_m = ar;
    re_m = r && !ar;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    wdata     = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    chk("we_reset", 64'(bus.we), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    repeat (3) step(0, 0, '0);

    // Fill to full, then one rejected push.
    for (int i = 0; i < DEP; i++) step(1, 0, DW'((i + 1) * 32'h11));
    step(1, 0, 32'hDEAD_BEEF);

    // Drain in order, then one rejected pop (dout holds 0x88).
    for (int i = 0; i < DEP; i++) step(0, 1, '0);
    step(0, 1, '0);

    // Pointer wrap: wAddr runs 5,6,7,0,1,2 during the six pushes.
    for (int i = 0; i < 5; i++) step(1, 0, DW'(32'hA0 + i));
    for (int i = 0; i < 5; i++) step(0, 1, '0);
    for (int i = 0; i < 6; i++) step(1, 0, DW'(32'hB0 + i));
    for (int i = 0; i < 6; i++) step(0, 1, '0);

    // Simultaneous push/pop at count 3, empty and full.
    for (int i = 0; i < 3; i++) step(1, 0, DW'(32'hC0 + i));
    step(1, 1, 32'hC3);
    for (int i = 0; i < 3; i++) step(0, 1, '0);
    step(1, 1, 32'hD0);
    for (int i = 0; i < DEP - 1; i++) step(1, 0, DW'(32'hE0 + i));
    step(1, 1, 32'hF0);
    for (int i = 0; i < 3; i++) step(0, 1, '0);

    // Partial-cycle reset with four entries held.
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    chk("count_before_reset", 64'(bus.data_count), 64'(4));
    #1 reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    chk("we_midreset",    64'(bus.we),    64'(0));
    chk("wAddr_midreset", 64'(bus.wAddr), 64'(0));
    chk("rAddr_midreset", 64'(bus.rAddr), 64'(0));
    #1 reset = 1'b0;

    // Randomized traffic: a write-biased phase then a read-biased phase.
    for (int i = 0; i < 300; i++) begin
      bit w, r;
      if (i < 150) begin
        w = ($urandom_range(0, 99) < 65);
        r = ($urandom_range(0, 99) < 35);
      end else begin
        w = ($urandom_range(0, 99) < 35);
        r = ($urandom_range(0, 99) < 65);
      end
      step(w, r, $urandom);
    end
    step(0, 0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
